uart_host_bridge: RTL and testbench
===================================

Name: uart_host_bridge

Overview:
Host-side peer of the SoC's simulation UART port (io_uart_out_* / io_uart_in_*).
- Absorbs characters the core emits into an RX FIFO, drained by the host or testbench over a valid/ready stream.
- Serves the core's character-read requests from a TX FIFO, filled by the host over a valid/ready stream.
- Instanced beside SimTop in the top wrapper, replacing the open-circuit UART hookup.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries each).
EMPTY_CH, 8'hFF, character returned to the core when the TX FIFO is empty (-1 convention).
CNT_W, 16, width of the saturating drop and read counters.

Ports:
clock  input  1  single clock for all logic.
reset  input  1  asynchronous, active-high reset.
io_uart_out_valid  input  1  core emits a character this cycle.
io_uart_out_ch  input  8  emitted character.
io_uart_in_valid  input  1  core reads a character this cycle.
io_uart_in_ch  output  8  character returned to the core, same cycle as the read.
host_rx_valid  output  1  RX FIFO non-empty.
host_rx_ready  input  1  host accepts the RX head.
host_rx_data  output  8  RX FIFO head.
host_tx_valid  input  1  host offers a character for the core.
host_tx_ready  output  1  TX FIFO not full.
host_tx_data  input  8  offered character.
rx_drop_cnt  output  CNT_W  emitted chars lost to a full RX FIFO, saturating.
rx_overflow  output  1  sticky; set on the first drop.
in_empty_cnt  output  CNT_W  core reads served with EMPTY_CH, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - Both FIFOs empty; pointers are DEPTH_LOG2+1 bits wide.
  - All counters 0; rx_overflow 0.
  - Outputs at reset: host_rx_valid=0, host_tx_ready=1, io_uart_in_ch=EMPTY_CH, host_rx_data=8'h00 (RAM contents are don't-care; output muxed to 0 when empty).
- RX path, core to host:
  - Push when io_uart_out_valid=1. The core has no backpressure.
  - If full and no simultaneous pop: the character is dropped, rx_drop_cnt increments (saturating at all-ones) and rx_overflow is set.
  - Pop on host_rx_valid && host_rx_ready.
  - Full with push and pop in the same cycle: the push is accepted, nothing is dropped, occupancy is unchanged.
  - Empty with push and pop in the same cycle: the pop is invalid because host_rx_valid=0; the push lands.
  - Write-to-read latency is 1 cycle: a pushed char appears on host_rx_data with host_rx_valid=1 on the next edge. There is no same-cycle bypass.
- TX path, host to core:
  - Push on host_tx_valid && host_tx_ready.
  - io_uart_in_ch is combinational: the TX head when non-empty, else EMPTY_CH.
  - When io_uart_in_valid=1 and the FIFO is non-empty, the head pops at the clock edge.
  - When io_uart_in_valid=1 and the FIFO is empty: no pop, and in_empty_cnt increments (saturating).
  - Full with host push and core pop in the same cycle: host_tx_ready is 0 because the FIFO is full, so only the pop occurs.
  - Empty with host push in a cycle: a core read in that same cycle still sees EMPTY_CH. The new char is visible from the next cycle.
- Pointers:
  - Wrap modulo 2^DEPTH_LOG2 on the low bits.
  - Full means the MSBs differ and the low bits are equal; empty means all bits are equal.
- Counters and flags:
  - Counters never wrap; they hold at 2^CNT_W-1.
  - rx_overflow clears only on reset.
- No internal state machine beyond the FIFO pointers and counters.
- Reset asserted mid-stream empties both FIFOs immediately. Characters in flight are lost and not counted.

Test Plan:
1. RX order: core emits 'H','i','\n' (0x48,0x69,0x0A) on 3 consecutive cycles with host_rx_ready=0. Then assert ready → host_rx_data reads 0x48, 0x69, 0x0A on consecutive cycles, then host_rx_valid=0; rx_drop_cnt=0.
2. RX overflow: 18 emits with ready=0 → first 16 are retained, rx_drop_cnt=2, rx_overflow=1. Drain → exactly chars 1..16 in order. Then 1 more emit, drained → rx_overflow still 1.
3. RX full with simultaneous push/pop: fill 16 entries, then emit 0x41 in the same cycle the host pops → no drop, occupancy stays 16, and 0x41 emerges last.
4. TX serve: host pushes 0x31, 0x32. Core reads on 3 consecutive cycles → io_uart_in_ch = 0x31, 0x32, 0xFF; in_empty_cnt=1.
5. TX backpressure: host pushes 17 chars → host_tx_ready=0 after the 16th. One core read → ready returns to 1 next cycle, and the 17th char is accepted.
6. Reset mid-operation: with 5 RX and 3 TX entries held, pulse reset asynchronously between edges → host_rx_valid=0, io_uart_in_ch=0xFF and counters=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/uart_host_bridge.sv
// Host-side peer of the SoC simulation UART: an RX FIFO collects characters the core
// emits, and a TX FIFO answers the core's character reads (EMPTY_CH when nothing is queued).
module uart_host_bridge #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  EMPTY_CH   = 8'hFF,
  parameter int          CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_uart_out_valid,
  input  logic [7:0]       io_uart_out_ch,
  input  logic             io_uart_in_valid,
  output logic [7:0]       io_uart_in_ch,
  output logic             host_rx_valid,
  input  logic             host_rx_ready,
  output logic [7:0]       host_rx_data,
  input  logic             host_tx_valid,
  output logic             host_tx_ready,
  input  logic [7:0]       host_tx_data,
  output logic [CNT_W-1:0] rx_drop_cnt,
  output logic             rx_overflow,
  output logic [CNT_W-1:0] in_empty_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [7:0] rxMem [DEPTH];
  logic [7:0] txMem [DEPTH];
  ptr_t rxWr, rxRd, txWr, txRd;
  logic rxEmpty, rxFull, rxPush, rxPop, rxDrop;
  logic txEmpty, txFull, txPush, txPop, emptyRead;

  // Extra MSB distinguishes full from empty when the low bits match.
  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[DEPTH_LOG2] != rxRd[DEPTH_LOG2]) &&
                   (rxWr[DEPTH_LOG2-1:0] == rxRd[DEPTH_LOG2-1:0]);
  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[DEPTH_LOG2] != txRd[DEPTH_LOG2]) &&
                   (txWr[DEPTH_LOG2-1:0] == txRd[DEPTH_LOG2-1:0]);

  // A pop frees the slot being written, so a full FIFO still takes a push that cycle.
  assign rxPop     = !rxEmpty && host_rx_ready;
  assign rxPush    = io_uart_out_valid && (!rxFull || rxPop);
  assign rxDrop    = io_uart_out_valid && rxFull && !rxPop;
  assign txPush    = host_tx_valid && !txFull;
  assign txPop     = io_uart_in_valid && !txEmpty;
  assign emptyRead = io_uart_in_valid && txEmpty;

  assign host_rx_valid = !rxEmpty;
  assign host_rx_data  = rxEmpty ? 8'h00 : rxMem[rxRd[DEPTH_LOG2-1:0]];
  assign host_tx_ready = !txFull;
  assign io_uart_in_ch = txEmpty ? EMPTY_CH : txMem[txRd[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock) begin
    if (rxPush) rxMem[rxWr[DEPTH_LOG2-1:0]] <= io_uart_out_ch;
    if (txPush) txMem[txWr[DEPTH_LOG2-1:0]] <= host_tx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxWr         <= '0;
      rxRd         <= '0;
      txWr         <= '0;
      txRd         <= '0;
      rx_drop_cnt  <= '0;
      rx_overflow  <= 1'b0;
      in_empty_cnt <= '0;
    end else begin
      if (rxPush) rxWr <= rxWr + 1'b1;
      if (rxPop)  rxRd <= rxRd + 1'b1;
      if (txPush) txWr <= txWr + 1'b1;
      if (txPop)  txRd <= txRd + 1'b1;
      if (rxDrop) begin
        rx_overflow <= 1'b1;
        if (rx_drop_cnt != '1) rx_drop_cnt <= rx_drop_cnt + 1'b1;
      end
      if (emptyRead && in_empty_cnt != '1) in_empty_cnt <= in_empty_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: RX ordering/overflow, TX serve/backpressure, async reset.
module tb_uart_host_bridge;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_uart_out_valid = 1'b0;
  logic [7:0]  io_uart_out_ch = 8'h00;
  logic        io_uart_in_valid = 1'b0;
  logic [7:0]  io_uart_in_ch;
  logic        host_rx_valid;
  logic        host_rx_ready = 1'b0;
  logic [7:0]  host_rx_data;
  logic        host_tx_valid = 1'b0;
  logic        host_tx_ready;
  logic [7:0]  host_tx_data = 8'h00;
  logic [15:0] rx_drop_cnt;
  logic        rx_overflow;
  logic [15:0] in_empty_cnt;

  int checks = 0;
  int errors = 0;

  uart_host_bridge #(.DEPTH_LOG2(4), .EMPTY_CH(8'hFF), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .io_uart_out_valid(io_uart_out_valid), .io_uart_out_ch(io_uart_out_ch),
    .io_uart_in_valid(io_uart_in_valid), .io_uart_in_ch(io_uart_in_ch),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready), .host_rx_data(host_rx_data),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready), .host_tx_data(host_tx_data),
    .rx_drop_cnt(rx_drop_cnt), .rx_overflow(rx_overflow), .in_empty_cnt(in_empty_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", host_rx_valid); end
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", host_tx_ready); end
    checks++; if (io_uart_in_ch !== 8'hFF) begin errors++; $display("FAIL reset_in_ch got %h want ff", io_uart_in_ch); end
    checks++; if (host_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", host_rx_data); end
    checks++; if (rx_drop_cnt !== 16'd0 || in_empty_cnt !== 16'd0 || rx_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_counters got drop=%0d empty=%0d ovf=%b want 0 0 0", rx_drop_cnt, in_empty_cnt, rx_overflow);
    end
  endtask

  task automatic test_rx_order();
    logic [7:0] msg [3];
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      io_uart_out_valid = 1'b1; io_uart_out_ch = msg[i];
      tick();
    end
    io_uart_out_valid = 1'b0;
    host_rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== msg[i]) begin
        errors++; $display("FAIL rx_order[%0d] got v=%b %h want v=1 %h", i, host_rx_valid, host_rx_data, msg[i]);
      end
      tick();
    end
    host_rx_ready = 1'b0;
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL rx_order_empty got %b want 0", host_rx_valid); end
    checks++; if (rx_drop_cnt !== 16'd0) begin errors++; $display("FAIL rx_order_drop got %0d want 0", rx_drop_cnt); end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 18; i++) begin
      io_uart_out_valid = 1'b1; io_uart_out_ch = 8'(i + 1);
      tick();
    end
    io_uart_out_valid = 1'b0;
    checks++; if (rx_drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 2", rx_drop_cnt); end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", rx_overflow); end
    host_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_drain[%0d] got v=%b %h want v=1 %h", i, host_rx_valid, host_rx_data, 8'(i + 1));
      end
      tick();
    end
    host_rx_ready = 1'b0;
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", host_rx_valid); end
    io_uart_out_valid = 1'b1; io_uart_out_ch = 8'h55;
    tick();
    io_uart_out_valid = 1'b0;
    checks++; if (host_rx_data !== 8'h55) begin errors++; $display("FAIL ovf_extra got %h want 55", host_rx_data); end
    host_rx_ready = 1'b1;
    tick();
    host_rx_ready = 1'b0;
    checks++; if (rx_overflow !== 1'b1 || rx_drop_cnt !== 16'd2 || host_rx_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky got ovf=%b drop=%0d v=%b want 1 2 0", rx_overflow, rx_drop_cnt, host_rx_valid);
    end
  endtask

  task automatic test_rx_full_pushpop();
    for (int i = 0; i < 16; i++) begin
      io_uart_out_valid = 1'b1; io_uart_out_ch = 8'hA0 + 8'(i);
      tick();
    end
    io_uart_out_ch = 8'h41; host_rx_ready = 1'b1;
    checks++; if (host_rx_data !== 8'hA0) begin errors++; $display("FAIL full_pp_head got %h want a0", host_rx_data); end
    tick();
    io_uart_out_valid = 1'b0;
    checks++; if (rx_drop_cnt !== 16'd2) begin errors++; $display("FAIL full_pp_drop got %0d want 2", rx_drop_cnt); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h41 : 8'hA1 + 8'(i);
      checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== exp) begin
        errors++; $display("FAIL full_pp_drain[%0d] got v=%b %h want v=1 %h", i, host_rx_valid, host_rx_data, exp);
      end
      tick();
    end
    host_rx_ready = 1'b0;
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got %b want 0", host_rx_valid); end
  endtask

  task automatic test_tx_serve();
    logic [7:0] exp [3];
    exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'hFF;
    host_tx_valid = 1'b1; host_tx_data = 8'h31; tick();
    host_tx_data = 8'h32; tick();
    host_tx_valid = 1'b0;
    io_uart_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (io_uart_in_ch !== exp[i]) begin errors++; $display("FAIL tx_serve[%0d] got %h want %h", i, io_uart_in_ch, exp[i]); end
      tick();
    end
    io_uart_in_valid = 1'b0;
    checks++; if (in_empty_cnt !== 16'd1) begin errors++; $display("FAIL tx_empty_cnt got %0d want 1", in_empty_cnt); end
    // push and read in the same cycle on an empty FIFO
    host_tx_valid = 1'b1; host_tx_data = 8'h77; io_uart_in_valid = 1'b1;
    checks++; if (io_uart_in_ch !== 8'hFF) begin errors++; $display("FAIL tx_same_cycle got %h want ff", io_uart_in_ch); end
    tick();
    host_tx_valid = 1'b0; io_uart_in_valid = 1'b0;
    checks++; if (io_uart_in_ch !== 8'h77 || in_empty_cnt !== 16'd2) begin
      errors++; $display("FAIL tx_next_cycle got %h cnt=%0d want 77 cnt=2", io_uart_in_ch, in_empty_cnt);
    end
    io_uart_in_valid = 1'b1; tick(); io_uart_in_valid = 1'b0;
  endtask

  task automatic test_tx_backpressure();
    host_tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_tx_data = 8'hB0 + 8'(i);
      tick();
    end
    host_tx_data = 8'hC0;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", host_tx_ready); end
    tick();
    checks++; if (io_uart_in_ch !== 8'hB0 || host_tx_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got %h rdy=%b want b0 rdy=0", io_uart_in_ch, host_tx_ready);
    end
    io_uart_in_valid = 1'b1;
    tick();
    io_uart_in_valid = 1'b0;
    checks++; if (host_tx_ready !== 1'b1 || io_uart_in_ch !== 8'hB1) begin
      errors++; $display("FAIL bp_release got rdy=%b %h want rdy=1 b1", host_tx_ready, io_uart_in_ch);
    end
    tick();
    host_tx_valid = 1'b0;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL bp_refull got %b want 0", host_tx_ready); end
    io_uart_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'hC0 : 8'hB1 + 8'(i);
      checks++; if (io_uart_in_ch !== exp) begin errors++; $display("FAIL bp_drain[%0d] got %h want %h", i, io_uart_in_ch, exp); end
      tick();
    end
    io_uart_in_valid = 1'b0;
    checks++; if (in_empty_cnt !== 16'd2 || io_uart_in_ch !== 8'hFF) begin
      errors++; $display("FAIL bp_end got cnt=%0d %h want 2 ff", in_empty_cnt, io_uart_in_ch);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      io_uart_out_valid = 1'b1; io_uart_out_ch = 8'h60 + 8'(i);
      host_tx_valid = (i < 3); host_tx_data = 8'h70 + 8'(i);
      tick();
    end
    io_uart_out_valid = 1'b0; host_tx_valid = 1'b0;
    checks++; if (host_rx_valid !== 1'b1 || io_uart_in_ch !== 8'h70 || in_empty_cnt === 16'd0) begin
      errors++; $display("FAIL mid_loaded got v=%b %h cnt=%0d want v=1 70 cnt>0", host_rx_valid, io_uart_in_ch, in_empty_cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (host_rx_valid !== 1'b0 || io_uart_in_ch !== 8'hFF || host_tx_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_fifos got v=%b %h rdy=%b want 0 ff 1", host_rx_valid, io_uart_in_ch, host_tx_ready);
    end
    checks++; if (rx_drop_cnt !== 16'd0 || in_empty_cnt !== 16'd0 || rx_overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset_cnt got drop=%0d empty=%0d ovf=%b want 0 0 0", rx_drop_cnt, in_empty_cnt, rx_overflow);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_rx_order();
    test_rx_overflow();
    test_rx_full_pushpop();
    test_tx_serve();
    test_tx_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
